// File: rtl/bcd_arb.sv
// Round-robin arbiter sharing one pipelined bin2bcd converter among N_REQ requesters.
// Define BCD_ARB_RR_EN for the rotating priority pointer; otherwise the lowest index always wins.
module bcd_arb #(
    parameter int N_REQ = 4,
    parameter int LAT   = 6,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [N_REQ*11-1:0]   req_bin,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [10:0]           conv_bin,
    output logic                  conv_vld,
    input  logic [16:0]           conv_bcd,
    input  logic                  conv_bcd_vld,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [16:0]           rsp_bcd,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  err
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] idx;
    logic            grant;

    // One tag per converter stage plus the issue register, so the last tag
    // lines up with conv_bcd_vld.
    logic [LAT:0]    tag_vld;
    logic [ID_W-1:0] tag_id [LAT+1];

    always_comb begin
        req_rdy  = '0;
        grant    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = ID_W'((int'(ptr) + off) % N_REQ);
            if (!grant && req_vld[idx]) begin
                grant        = 1'b1;
                grant_id     = idx;
                req_rdy[idx] = 1'b1;
            end
        end
    end

`ifdef BCD_ARB_RR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            conv_bin <= '0;
            conv_vld <= 1'b0;
            tag_vld  <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id[s] <= '0;
            end
            rsp_vld  <= '0;
            rsp_bcd  <= '0;
            rsp_id   <= '0;
            err      <= 1'b0;
        end else begin
            if (grant) begin
                conv_bin  <= req_bin[grant_id*11 +: 11];
                conv_vld  <= 1'b1;
                tag_id[0] <= grant_id;
            end else begin
                conv_bin  <= '0;
                conv_vld  <= 1'b0;
                tag_id[0] <= '0;
            end
            tag_vld <= {tag_vld[LAT-1:0], grant};
            for (int s = 1; s <= LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end

            // Responses are steered by the tag alone; the converter valid only feeds err.
            if (tag_vld[LAT]) begin
                rsp_vld <= N_REQ'(1) << tag_id[LAT];
                rsp_id  <= tag_id[LAT];
                rsp_bcd <= conv_bcd;
            end else begin
                rsp_vld <= '0;
                rsp_id  <= '0;
                rsp_bcd <= '0;
            end

            err <= err | (conv_bcd_vld ^ tag_vld[LAT]);
        end
    end

endmodule
